// File: rtl/mb8_arbiter_pkg.sv
// Shared types and defaults for the mb8 byte-memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mb8_arbiter_pkg;

    // Bus ownership state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CORE = 2'd1,
        HOST = 2'd2
    } arb_st_t;

    // Previous owner. Used to break a tie when both ports request from IDLE.
    typedef enum logic {
        LAST_C = 1'b0,
        LAST_H = 1'b1
    } arb_last_t;

    localparam int ARB_BURST_DEF = 8;
    localparam int ARB_ASZ_DEF   = 17;

endpackage

// File: rtl/mb8_arbiter_if.sv
// mb8 bus bundle: core and host request ports, shared read return, memory port.
// Latency: n/a (wiring only).
// Backpressure: a requester holds req/we/addr/wd until it sees its gnt.
// Modports: slave  = the arbiter's view (requests and m_rd in; grants, rvld, rd and m_* out).
//           master = the requester/memory side's view (the mirror image).
interface mb8_arbiter_if #(
    parameter int ASZ = 17
) ();
    logic           c_req;
    logic           c_we;
    logic [ASZ-1:0] c_addr;
    logic [7:0]     c_wd;
    logic           c_gnt;
    logic           c_rvld;

    logic           h_req;
    logic           h_we;
    logic [ASZ-1:0] h_addr;
    logic [7:0]     h_wd;
    logic           h_gnt;
    logic           h_rvld;

    logic [7:0]     rd;

    logic           m_en;
    logic           m_we;
    logic [ASZ-1:0] m_addr;
    logic [7:0]     m_wd;
    logic [7:0]     m_rd;

    modport slave (
        input  c_req, c_we, c_addr, c_wd,
        output c_gnt, c_rvld,
        input  h_req, h_we, h_addr, h_wd,
        output h_gnt, h_rvld,
        output rd,
        output m_en, m_we, m_addr, m_wd,
        input  m_rd
    );

    modport master (
        output c_req, c_we, c_addr, c_wd,
        input  c_gnt, c_rvld,
        output h_req, h_we, h_addr, h_wd,
        input  h_gnt, h_rvld,
        input  rd,
        input  m_en, m_we, m_addr, m_wd,
        output m_rd
    );
endinterface

// File: rtl/mb8_arb_fsm.sv
// Ownership sequencer: decides who owns the mb8 bus next (owner, last owner, burst count).
// Latency: ownership changes on the clock edge; IDLE->owner costs one cycle, owner->owner none.
// Backpressure: an owner is pre-empted after BURST consecutive cycles while the other port waits.
// Ports: clk, rst (async active-high); c_req_i/h_req_i request levels; owner_o current owner.
module mb8_arb_fsm
    import mb8_arbiter_pkg::*;
#(
    parameter int BURST = ARB_BURST_DEF
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    c_req_i,
    input  logic    h_req_i,
    output arb_st_t owner_o
);

    localparam logic [7:0] BMAX = 8'(BURST - 1);

    arb_st_t    owner_q, owner_d;
    arb_last_t  last_q,  last_d;
    logic [7:0] bcnt_q,  bcnt_d;

    // Owner-relative view so CORE and HOST share one set of rules.
    logic       own_req;
    logic       oth_req;
    arb_st_t    oth_st;
    arb_last_t  own_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= IDLE;
            last_q  <= LAST_C;
            bcnt_q  <= '0;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
            bcnt_q  <= bcnt_d;
        end
    end

    always_comb begin
        owner_d  = owner_q;
        last_d   = last_q;
        bcnt_d   = bcnt_q;
        own_req  = 1'b0;
        oth_req  = 1'b0;
        oth_st   = IDLE;
        own_last = LAST_C;

        case (owner_q)
            CORE: begin
                own_req  = c_req_i;
                oth_req  = h_req_i;
                oth_st   = HOST;
                own_last = LAST_C;
            end
            HOST: begin
                own_req  = h_req_i;
                oth_req  = c_req_i;
                oth_st   = CORE;
                own_last = LAST_H;
            end
            default: ;
        endcase

        if (owner_q == IDLE) begin
            bcnt_d = '0;
            if (c_req_i && h_req_i) begin
                owner_d = (last_q == LAST_C) ? HOST : CORE;
            end else if (c_req_i) begin
                owner_d = CORE;
            end else if (h_req_i) begin
                owner_d = HOST;
            end
        end else if (!own_req) begin
            // Owner released the bus: hand straight over, or fall idle.
            // An illegal state encoding lands here too and recovers to IDLE.
            owner_d = oth_req ? oth_st : IDLE;
            bcnt_d  = '0;
            last_d  = own_last;
        end else if (oth_req && (bcnt_q == BMAX)) begin
            // Burst exhausted with the other port waiting: pre-empt.
            owner_d = oth_st;
            bcnt_d  = '0;
            last_d  = own_last;
        end else if (bcnt_q != BMAX) begin
            // Saturating count, so a lone owner is pre-empted on the first
            // cycle the other port shows up once it has held the bus long enough.
            bcnt_d = bcnt_q + 8'd1;
        end
    end

    assign owner_o = owner_q;

endmodule

// File: rtl/mb8_arbiter.sv
// Two-port (core/host) arbiter for the shared 8-bit mb8 memory port; routes read-valid to the issuer.
// Latency: grant is combinational on owner+req; rvld arrives one cycle after a granted read.
// Backpressure: a requester without gnt must hold its request; a dropped request is a no-op.
// Ports: clk, rst (async active-high); bus (mb8_arbiter_if.slave) carries all handshake and
// memory signals. With MB8_ARB_STATS_EN defined, c_cnt/h_cnt (granted cycles per port) and
// stall_cnt (cycles with a request waiting) are added; they wrap at 2^32.
module mb8_arbiter
    import mb8_arbiter_pkg::*;
#(
    parameter int ASZ   = ARB_ASZ_DEF,
    parameter int BURST = ARB_BURST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    mb8_arbiter_if.slave bus
`ifdef MB8_ARB_STATS_EN
    ,
    output logic [31:0] c_cnt,
    output logic [31:0] h_cnt,
    output logic [31:0] stall_cnt
`endif
);

    arb_st_t        owner;
    logic           c_gnt;
    logic           h_gnt;
    logic           c_rvld_q;
    logic           h_rvld_q;
    logic           m_we;
    logic [ASZ-1:0] m_addr;
    logic [7:0]     m_wd;

    mb8_arb_fsm #(
        .BURST (BURST)
    ) u_fsm (
        .clk     (clk),
        .rst     (rst),
        .c_req_i (bus.c_req),
        .h_req_i (bus.h_req),
        .owner_o (owner)
    );

    assign c_gnt = (owner == CORE) && bus.c_req;
    assign h_gnt = (owner == HOST) && bus.h_req;

    // At most one grant is ever active; idle cycles drive zeros to memory.
    always_comb begin
        m_we   = 1'b0;
        m_addr = '0;
        m_wd   = '0;
        if (c_gnt) begin
            m_we   = bus.c_we;
            m_addr = bus.c_addr;
            m_wd   = bus.c_wd;
        end else if (h_gnt) begin
            m_we   = bus.h_we;
            m_addr = bus.h_addr;
            m_wd   = bus.h_wd;
        end
    end

    // Read-valid is tagged by the port that issued the read, so data stays
    // with its issuer even if ownership moved on at the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_rvld_q <= 1'b0;
            h_rvld_q <= 1'b0;
        end else begin
            c_rvld_q <= c_gnt && !bus.c_we;
            h_rvld_q <= h_gnt && !bus.h_we;
        end
    end

    assign bus.c_gnt  = c_gnt;
    assign bus.h_gnt  = h_gnt;
    assign bus.c_rvld = c_rvld_q;
    assign bus.h_rvld = h_rvld_q;
    assign bus.rd     = bus.m_rd;
    assign bus.m_en   = c_gnt || h_gnt;
    assign bus.m_we   = m_we;
    assign bus.m_addr = m_addr;
    assign bus.m_wd   = m_wd;

`ifdef MB8_ARB_STATS_EN
    logic [31:0] c_cnt_q;
    logic [31:0] h_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_cnt_q     <= '0;
            h_cnt_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (c_gnt) c_cnt_q <= c_cnt_q + 32'd1;
            if (h_gnt) h_cnt_q <= h_cnt_q + 32'd1;
            // One count per cycle in which any request is left waiting.
            if ((bus.c_req && !c_gnt) || (bus.h_req && !h_gnt)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign c_cnt     = c_cnt_q;
    assign h_cnt     = h_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mb8_arbiter.sv
// Self-checking bench for mb8_arbiter: directed scenarios plus constrained-random traffic
// compared every cycle against a tenure-based reference model and a byte-memory image.
module tb_mb8_arbiter;

    localparam int ASZ      = 17;
    localparam int TB_BURST = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mb8_arbiter_if #(.ASZ(ASZ)) bus ();

`ifdef MB8_ARB_STATS_EN
    logic [31:0] c_cnt;
    logic [31:0] h_cnt;
    logic [31:0] stall_cnt;
`endif

    mb8_arbiter #(
        .ASZ   (ASZ),
        .BURST (TB_BURST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MB8_ARB_STATS_EN
        ,
        .c_cnt     (c_cnt),
        .h_cnt     (h_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    // Memory behind the arbiter: synchronous, one-cycle read latency.
    logic [7:0] ram [0:(1<<ASZ)-1];
    always @(posedge clk) begin
        if (bus.m_en) begin
            if (bus.m_we) ram[bus.m_addr] <= bus.m_wd;
            else          bus.m_rd <= ram[bus.m_addr];
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  mdl_mem [0:(1<<ASZ)-1];
    int          m_own;    // 0 nobody, 1 core, 2 host
    int          m_last;   // 1 core, 2 host
    int          m_run;    // cycles the current owner has held the bus
    bit          e_crv, e_hrv;
    logic [7:0]  e_cdat, e_hdat;
    logic [31:0] e_ccnt, e_hcnt, e_stall;

    int n_cmp = 0;
    int n_bad = 0;
    bit obs_cg, obs_hg;
    int g_c, g_h;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        m_own   = 0;
        m_last  = 1;
        m_run   = 0;
        e_crv   = 1'b0;
        e_hrv   = 1'b0;
        e_ccnt  = '0;
        e_hcnt  = '0;
        e_stall = '0;
    endtask

    // Apply one clock edge to the model, using the inputs present at that edge.
    task automatic mdl_edge();
        bit cg, hg, own, oth;
        cg = (m_own == 1) && bus.c_req;
        hg = (m_own == 2) && bus.h_req;
        e_crv = cg && !bus.c_we;
        e_hrv = hg && !bus.h_we;
        if (e_crv) e_cdat = mdl_mem[bus.c_addr];
        if (e_hrv) e_hdat = mdl_mem[bus.h_addr];
        if (cg && bus.c_we) mdl_mem[bus.c_addr] = bus.c_wd;
        if (hg && bus.h_we) mdl_mem[bus.h_addr] = bus.h_wd;
        if (cg) e_ccnt++;
        if (hg) e_hcnt++;
        if ((bus.c_req && !cg) || (bus.h_req && !hg)) e_stall++;

        if (m_own == 0) begin
            m_run = 0;
            if (bus.c_req && bus.h_req) m_own = (m_last == 1) ? 2 : 1;
            else if (bus.c_req)         m_own = 1;
            else if (bus.h_req)         m_own = 2;
        end else begin
            own = (m_own == 1) ? bus.c_req : bus.h_req;
            oth = (m_own == 1) ? bus.h_req : bus.c_req;
            if (!own || (oth && m_run >= TB_BURST - 1)) begin
                m_last = m_own;
                m_own  = oth ? 3 - m_own : 0;
                m_run  = 0;
            end else begin
                m_run++;
            end
        end
    endtask

    task automatic check_outputs();
        bit         cg, hg, ewe;
        logic [16:0] eaddr;
        logic [7:0]  ewd;
        cg    = (m_own == 1) && bus.c_req;
        hg    = (m_own == 2) && bus.h_req;
        ewe   = cg ? bus.c_we   : (hg ? bus.h_we   : 1'b0);
        eaddr = cg ? bus.c_addr : (hg ? bus.h_addr : '0);
        ewd   = cg ? bus.c_wd   : (hg ? bus.h_wd   : '0);
        chk("c_gnt",  bus.c_gnt,  cg);
        chk("h_gnt",  bus.h_gnt,  hg);
        chk("m_en",   bus.m_en,   cg || hg);
        chk("m_we",   bus.m_we,   ewe);
        chk("m_addr", bus.m_addr, eaddr);
        chk("m_wd",   bus.m_wd,   ewd);
        chk("c_rvld", bus.c_rvld, e_crv);
        chk("h_rvld", bus.h_rvld, e_hrv);
        if (e_crv) chk("c_rd", bus.rd, e_cdat);
        if (e_hrv) chk("h_rd", bus.rd, e_hdat);
`ifdef MB8_ARB_STATS_EN
        chk("c_cnt",     c_cnt,     e_ccnt);
        chk("h_cnt",     h_cnt,     e_hcnt);
        chk("stall_cnt", stall_cnt, e_stall);
`endif
        obs_cg = bus.c_gnt;
        obs_hg = bus.h_gnt;
    endtask

    // One cycle: inputs were set at the preceding negedge. Optionally pulse
    // reset asynchronously in the middle of the cycle.
    task automatic step(input bit do_rst);
        #1;
        check_outputs();
        if (obs_cg) g_c++;
        if (obs_hg) g_h++;
        if (do_rst) begin
            rst = 1'b1;
            #1;
            mdl_reset();
            check_outputs();
            rst = 1'b0;
        end
        @(posedge clk);
        mdl_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.c_req = 1'b0;
        bus.h_req = 1'b0;
        mdl_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_gnt(input bit port_h, input string tag);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            step(1'b0);
            got = port_h ? obs_hg : obs_cg;
        end
        chk(tag, got, 1'b1);
    endtask

    initial begin
        bit c_pend, h_pend;
        int first_own;

        bus.c_req = 0; bus.c_we = 0; bus.c_addr = '0; bus.c_wd = '0;
        bus.h_req = 0; bus.h_we = 0; bus.h_addr = '0; bus.h_wd = '0;
        bus.m_rd  = '0;
        for (int i = 'h1000; i < 'h1800; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            ram[i]     = b;
            mdl_mem[i] = b;
        end
        @(negedge clk);

        // Reset in the middle of a granted core read: the read must vanish.
        do_reset();
        bus.c_req = 1; bus.c_we = 0; bus.c_addr = 17'h1000;
        step(1'b0);
        step(1'b1);
        #1;
        chk("t1_c_rvld_after_rst", bus.c_rvld, 1'b0);
        bus.c_req = 0;
        step(1'b0);

        // Core alone reads 0x1000..0x1003 back to back.
        do_reset();
        bus.c_we = 0; bus.c_addr = 17'h1000; bus.c_req = 1;
        for (int a = 0; a < 4; a++) begin
            wait_gnt(1'b0, "t2_gnt");
            bus.c_addr = bus.c_addr + 17'd1;
        end
        bus.c_req = 0;
        step(1'b0);
        step(1'b0);

        // Continuous contention from IDLE with last = core.
        do_reset();
        bus.c_req = 1; bus.c_we = 0; bus.c_addr = 17'h1005;
        bus.h_req = 1; bus.h_we = 0; bus.h_addr = 17'h1006;
        g_c = 0; g_h = 0; first_own = 0;
        for (int k = 0; k < 32; k++) begin
            step(1'b0);
            if (first_own == 0 && (obs_cg || obs_hg)) first_own = obs_hg ? 2 : 1;
        end
        chk("t3_total",   g_c + g_h, 31);
        chk("t3_h_grants", g_h, 16);
        chk("t3_c_grants", g_c, 15);
        chk("t3_first",    first_own, 2);
`ifdef MB8_ARB_STATS_EN
        chk("t3_c_cnt",     c_cnt,     15);
        chk("t3_h_cnt",     h_cnt,     16);
        chk("t3_stall_cnt", stall_cnt, 32);
`endif
        bus.c_req = 0; bus.h_req = 0;
        step(1'b0);

        // Owner drops while host waits; core's last read still returns to core.
        do_reset();
        bus.c_req = 1; bus.c_we = 0; bus.c_addr = 17'h1001;
        wait_gnt(1'b0, "t4_c_gnt");
        bus.c_req = 0;
        bus.h_req = 1; bus.h_we = 0; bus.h_addr = 17'h1002;
        #1;
        chk("t4_c_rvld", bus.c_rvld, 1'b1);
        chk("t4_h_rvld", bus.h_rvld, 1'b0);
        step(1'b0);
        #1;
        chk("t4_h_gnt", bus.h_gnt, 1'b1);
        step(1'b0);
        bus.h_req = 0;
        step(1'b0);

        // Host write, core readback.
        do_reset();
        bus.h_req = 1; bus.h_we = 1; bus.h_addr = 17'h1400; bus.h_wd = 8'h2e;
        wait_gnt(1'b1, "t5_h_gnt");
        bus.h_req = 0; bus.h_we = 0;
        #1;
        chk("t5_no_h_rvld", bus.h_rvld, 1'b0);
        bus.c_req = 1; bus.c_we = 0; bus.c_addr = 17'h1400;
        wait_gnt(1'b0, "t5_c_gnt");
        bus.c_req = 0;
        #1;
        chk("t5_c_rvld", bus.c_rvld, 1'b1);
        chk("t5_rd",     bus.rd,     8'h2e);
        step(1'b0);

        // Random traffic honouring hold-until-grant, with rare drops and resets.
        do_reset();
        c_pend = 0; h_pend = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (c_pend && obs_cg) c_pend = 0;
            if (h_pend && obs_hg) h_pend = 0;
            if (c_pend && $urandom_range(31) == 0) c_pend = 0;
            if (h_pend && $urandom_range(31) == 0) h_pend = 0;
            if (!c_pend && $urandom_range(3) != 0) begin
                c_pend     = 1;
                bus.c_addr = 17'h1000 + 17'($urandom_range(15));
                bus.c_we   = ($urandom_range(2) == 0);
                bus.c_wd   = 8'($urandom);
            end
            if (!h_pend && $urandom_range(3) != 0) begin
                h_pend     = 1;
                bus.h_addr = 17'h1000 + 17'($urandom_range(15));
                bus.h_we   = ($urandom_range(2) == 0);
                bus.h_wd   = 8'($urandom);
            end
            bus.c_req = c_pend;
            bus.h_req = h_pend;
            step(cyc % 500 == 250);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
